cnt_event_gen: RTL and testbench
================================

Name: cnt_event_gen

Overview:
Upstream front-end for the up/down counter block. Turns two raw, possibly bouncing event inputs and a level clear request into clean single-cycle UP_ENABLE, UP_ENABLE2 and CLEAR pulses that feed the counter's enable and clear inputs directly. Provides synchronisation, debounce, same-cycle arbitration, a clear request/acknowledge handshake and a count of events dropped by a clear.

Parameters:
SYNC_STAGES, 2, synchroniser flop count per raw input (legal range 2..4).
DEB_CYCLES, 4, consecutive stable cycles before the filtered level changes (legal range 2..2**DEB_W-1).
DEB_W, 3, debounce counter width.
DROP_W, 8, width of the dropped-event counter.

Ports:
CLK  input  1  clock
RSTN  input  1  reset, asynchronous, active-low
EVT_A_RAW  input  1  raw event A, asynchronous to CLK
EVT_B_RAW  input  1  raw event B, asynchronous to CLK
CLR_REQ  input  1  level clear request, synchronous to CLK
UP_ENABLE  output  1  one-cycle pulse per debounced rising edge of A
UP_ENABLE2  output  1  one-cycle pulse per debounced rising edge of B
CLEAR  output  1  one-cycle clear pulse
CLR_ACK  output  1  clear acknowledge
DROP_CNT  output  DROP_W  saturating count of events discarded by a clear

Behaviour:
- Reset: all synchroniser flops, filtered levels, debounce counters, pending_b, DROP_CNT = 0. UP_ENABLE, UP_ENABLE2, CLEAR, CLR_ACK = 0. FSM = IDLE. Reset takes effect immediately at any point, including mid-debounce and mid-handshake.
- Synchroniser: SYNC_STAGES flop chain per raw input.
- Debounce (per input):
  - cnt clears to 0 on any cycle where synced == filtered.
  - Otherwise cnt increments. When cnt reaches DEB_CYCLES-1 while synced != filtered, filtered <= synced and cnt <= 0.
  - A glitch shorter than DEB_CYCLES synced cycles never changes filtered.
- Edge detect: rise_x is high for the one cycle after filtered_x goes 0->1. Falling edges produce nothing.
- Latency: edge 0 is the first CLK edge that samples raw high. The output pulse is high in the cycle after edge SYNC_STAGES+DEB_CYCLES (edge 6 with defaults). All outputs are registered.
- Arbitration (per cycle, priority order):
  - CLEAR cycle: rise_a, rise_b and pending_b are discarded. DROP_CNT += number discarded (0..2), saturating at all-ones.
  - Otherwise, UP_ENABLE = rise_a.
  - UP_ENABLE2 = pending_b or (rise_b and not rise_a).
  - If rise_a and rise_b coincide, pending_b <= 1 and UP_ENABLE2 fires the next cycle, so no increment is lost.
  - pending_b clears when it is emitted.
  - UP_ENABLE and UP_ENABLE2 are never high in the same cycle.
  - DEB_CYCLES >= 2 guarantees pending_b can never overflow.
- Clear FSM, states IDLE, PULSE, ACK:
  - IDLE: CLR_REQ=1 -> PULSE.
  - PULSE: CLEAR=1 for exactly one cycle -> ACK.
  - ACK: CLR_ACK=1, held while CLR_REQ=1. CLR_REQ=0 -> IDLE, with CLR_ACK low the next cycle.
  - CLR_REQ held high produces only one CLEAR; a new clear needs CLR_REQ low for at least one cycle.
  - Events pass normally during ACK.
- DROP_CNT is never cleared except by reset.

Decomposition:
- Shared package/include: FSM state encodings (IDLE=2'd0, PULSE=2'd1, ACK=2'd2), default parameter values.
- One sub-module, evt_debounce (synchroniser + debounce counter + rising-edge detect), instantiated twice with SYNC_STAGES, DEB_CYCLES, DEB_W.
- Arbitration, pending_b, clear FSM and DROP_CNT live in the top.

Test Plan:
1. Reset, then EVT_A_RAW rises cleanly and stays high -> UP_ENABLE high for exactly one cycle after edge 6. UP_ENABLE2 and CLEAR stay 0.
2. EVT_B_RAW toggles with 3-cycle high/low glitches for 40 cycles, then holds high -> no UP_ENABLE2 during the glitches, exactly one UP_ENABLE2 pulse after the final stable rise.
3. A and B raw rise on the same edge -> UP_ENABLE at cycle N, UP_ENABLE2 at cycle N+1, never both high together.
4. Same as 3, but CLR_REQ timed so PULSE coincides with rise_a/rise_b -> CLEAR=1, no enable pulses, DROP_CNT goes 0->2.
5. CLR_REQ held high for 10 cycles, then low -> one CLEAR pulse, CLR_ACK high from the next cycle until one cycle after CLR_REQ falls.
6. RSTN asserted while debounce cnt=2 and FSM=ACK -> all outputs 0 immediately. After release, a fresh A rise still needs the full 6-edge latency.

Source files
------------

// File: rtl/cnt_event_gen_pkg.sv
// Shared clear-FSM encoding, default parameter values and a small event-count helper
// for the counter event front-end.
package cnt_event_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    ACK   = 2'd2
  } clr_state_e;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DEB_CYCLES  = 4;
  localparam int DEF_DEB_W       = 3;
  localparam int DEF_DROP_W      = 8;

  function automatic logic [1:0] count3(input logic a, input logic b, input logic c);
    return {1'b0, a} + {1'b0, b} + {1'b0, c};
  endfunction

endpackage

// File: rtl/evt_debounce.sv
// Raw-input synchroniser, debounce filter and rising-edge detect.
// o_rise is high for the one cycle after the filtered level goes 0->1.
module evt_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4,
  parameter int DEB_W       = 3
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic i_raw,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DEB_W-1:0]       r_cnt;
  logic                   r_filt;
  logic                   r_filt_d;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  // The filtered level only follows the synced value after DEB_CYCLES disagreeing cycles in a row.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_cnt    <= '0;
      r_filt   <= 1'b0;
      r_filt_d <= 1'b0;
    end else begin
      r_filt_d <= r_filt;
      if (w_synced == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == DEB_W'(DEB_CYCLES - 1)) begin
        r_filt <= w_synced;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + DEB_W'(1);
      end
    end
  end

  assign o_rise = r_filt & ~r_filt_d;

endmodule

// File: rtl/cnt_event_gen.sv
// Counter front-end: clean UP_ENABLE/UP_ENABLE2/CLEAR pulses from raw events and a clear
// request, with same-cycle arbitration, clear handshake and a saturating dropped-event count.
module cnt_event_gen
  import cnt_event_gen_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int DEB_W       = DEF_DEB_W,
  parameter int DROP_W      = DEF_DROP_W
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              EVT_A_RAW,
  input  logic              EVT_B_RAW,
  input  logic              CLR_REQ,
  output logic              UP_ENABLE,
  output logic              UP_ENABLE2,
  output logic              CLEAR,
  output logic              CLR_ACK,
  output logic [DROP_W-1:0] DROP_CNT
);

  logic              w_rise_a;
  logic              w_rise_b;
  clr_state_e        r_state;
  clr_state_e        w_state_nxt;
  logic              r_pend_b;
  logic              r_up;
  logic              r_up2;
  logic              r_clear;
  logic              r_ack;
  logic [DROP_W-1:0] r_drop_cnt;
  logic              w_in_clear;
  logic              w_up_nxt;
  logic              w_up2_nxt;
  logic              w_pend_nxt;
  logic [1:0]        w_drop_n;
  logic [DROP_W:0]   w_drop_sum;
  logic [DROP_W-1:0] w_drop_nxt;

  evt_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_a (
    .CLK    (CLK),
    .RSTN   (RSTN),
    .i_raw  (EVT_A_RAW),
    .o_rise (w_rise_a)
  );

  evt_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_b (
    .CLK    (CLK),
    .RSTN   (RSTN),
    .i_raw  (EVT_B_RAW),
    .o_rise (w_rise_b)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (CLR_REQ) w_state_nxt = PULSE;
      PULSE:   w_state_nxt = ACK;
      ACK:     if (!CLR_REQ) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // The clear cycle swallows every pending increment; a coincident B is deferred one cycle.
  always_comb begin
    w_in_clear = (r_state == PULSE);
    w_up_nxt   = !w_in_clear && w_rise_a;
    w_up2_nxt  = !w_in_clear && (r_pend_b || (w_rise_b && !w_rise_a));
    w_pend_nxt = !w_in_clear && w_rise_a && w_rise_b;
    w_drop_n   = w_in_clear ? count3(w_rise_a, w_rise_b, r_pend_b) : 2'd0;
    w_drop_sum = {1'b0, r_drop_cnt} + {{(DROP_W-1){1'b0}}, w_drop_n};
    w_drop_nxt = w_drop_sum[DROP_W] ? '1 : w_drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state    <= IDLE;
      r_pend_b   <= 1'b0;
      r_up       <= 1'b0;
      r_up2      <= 1'b0;
      r_clear    <= 1'b0;
      r_ack      <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pend_b   <= w_pend_nxt;
      r_up       <= w_up_nxt;
      r_up2      <= w_up2_nxt;
      r_clear    <= w_in_clear;
      r_ack      <= (r_state == ACK);
      r_drop_cnt <= w_drop_nxt;
    end
  end

  assign UP_ENABLE  = r_up;
  assign UP_ENABLE2 = r_up2;
  assign CLEAR      = r_clear;
  assign CLR_ACK    = r_ack;
  assign DROP_CNT   = r_drop_cnt;

endmodule

// File: tb/tb_cnt_event_gen.sv
// Self-checking bench for cnt_event_gen: directed scenarios against fixed expectations,
// then randomized stimulus against a cycle-level reference model.
module tb_cnt_event_gen;

  localparam int S      = 2;
  localparam int D      = 4;
  localparam int DROP_W = 8;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic              CLK;
  logic              RSTN;
  logic              evt_a;
  logic              evt_b;
  logic              clr_req;
  logic              up;
  logic              up2;
  logic              clr;
  logic              ack;
  logic [DROP_W-1:0] drop;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic q_a[$];
  logic q_b[$];
  logic m_filt_a, m_filt_b, m_rise_a, m_rise_b, m_pend;
  int   m_run_a, m_run_b, m_phase, m_drop;
  logic m_up, m_up2, m_clr, m_ack;

  cnt_event_gen dut (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .EVT_A_RAW  (evt_a),
    .EVT_B_RAW  (evt_b),
    .CLR_REQ    (clr_req),
    .UP_ENABLE  (up),
    .UP_ENABLE2 (up2),
    .CLEAR      (clr),
    .CLR_ACK    (ack),
    .DROP_CNT   (drop)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic model_reset();
    q_a.delete();
    q_b.delete();
    for (int i = 0; i < S; i++) begin
      q_a.push_back(1'b0);
      q_b.push_back(1'b0);
    end
    m_filt_a = 0; m_filt_b = 0; m_rise_a = 0; m_rise_b = 0; m_pend = 0;
    m_run_a = 0; m_run_b = 0; m_phase = 0; m_drop = 0;
    m_up = 0; m_up2 = 0; m_clr = 0; m_ack = 0;
  endtask

  // Level flips once the synced input has disagreed with it for D consecutive cycles.
  task automatic deb(input logic s, input logic f_in, input int run_in,
                     output logic f_out, output int run_out, output logic rise);
    f_out = f_in;
    if (s == f_in) run_out = 0;
    else if (run_in + 1 == D) begin
      f_out   = s;
      run_out = 0;
    end else run_out = run_in + 1;
    rise = f_out & ~f_in;
  endtask

  task automatic model_step(input logic a, input logic b, input logic r);
    logic sa, sb, nf;
    int   n, nr;
    // phase 0: waiting, 1: clearing this cycle, 2: acknowledging
    m_clr = (m_phase == 1);
    m_ack = (m_phase == 2);
    if (m_phase == 1) begin
      n = int'(m_rise_a) + int'(m_rise_b) + int'(m_pend);
      m_drop = (m_drop + n > DROP_MAX) ? DROP_MAX : m_drop + n;
      m_up = 0; m_up2 = 0; m_pend = 0;
    end else begin
      m_up  = m_rise_a;
      m_up2 = m_pend | (m_rise_b & ~m_rise_a);
      m_pend = m_rise_a & m_rise_b;
    end
    if (m_phase == 0 && r) m_phase = 1;
    else if (m_phase == 1) m_phase = 2;
    else if (m_phase == 2 && !r) m_phase = 0;
    // input seen by the filter is the raw sample from S edges ago
    sa = q_a.pop_front(); q_a.push_back(a);
    sb = q_b.pop_front(); q_b.push_back(b);
    deb(sa, m_filt_a, m_run_a, nf, nr, m_rise_a); m_filt_a = nf; m_run_a = nr;
    deb(sb, m_filt_b, m_run_b, nf, nr, m_rise_b); m_filt_b = nf; m_run_b = nr;
  endtask

  // One clock edge: inputs already set by the caller, outputs settled on return.
  task automatic tick();
    logic a, b, r;
    a = evt_a; b = evt_b; r = clr_req;
    @(posedge CLK);
    model_step(a, b, r);
    #1;
  endtask

  task automatic do_reset();
    RSTN = 1'b0; evt_a = 1'b0; evt_b = 1'b0; clr_req = 1'b0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1 RSTN = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (up !== 1'b0) begin errors++; $display("FAIL reset_up got %b want 0", up); end
    checks++; if (up2 !== 1'b0) begin errors++; $display("FAIL reset_up2 got %b want 0", up2); end
    checks++; if (clr !== 1'b0) begin errors++; $display("FAIL reset_clear got %b want 0", clr); end
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", ack); end
    checks++; if (drop !== '0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop); end
  endtask

  task automatic test_a_latency();
    int first = -1, n_up = 0, n_other = 0;
    do_reset();
    tick(); tick();
    evt_a = 1'b1;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (up) begin n_up++; if (first < 0) first = k; end
      if (up2 || clr) n_other++;
    end
    checks++; if (first !== S + D) begin errors++; $display("FAIL a_latency edge got %0d want %0d", first, S + D); end
    checks++; if (n_up !== 1) begin errors++; $display("FAIL a_pulse_count got %0d want 1", n_up); end
    checks++; if (n_other !== 0) begin errors++; $display("FAIL a_other_outputs got %0d want 0", n_other); end
  endtask

  task automatic test_b_glitch();
    int n_glitch = 0, n_hold = 0, first = -1;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      evt_b = ((i / 3) % 2 == 0);
      tick();
      if (up2) n_glitch++;
    end
    evt_b = 1'b1;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (up2) begin n_hold++; if (first < 0) first = k; end
    end
    checks++; if (n_glitch !== 0) begin errors++; $display("FAIL b_glitch pulses got %0d want 0", n_glitch); end
    checks++; if (n_hold !== 1) begin errors++; $display("FAIL b_stable pulses got %0d want 1", n_hold); end
    checks++; if (first !== S + D) begin errors++; $display("FAIL b_latency edge got %0d want %0d", first, S + D); end
  endtask

  task automatic test_back_to_back();
    int e_up = -1, e_up2 = -1, both = 0;
    do_reset();
    tick();
    evt_a = 1'b1; evt_b = 1'b1;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (up && e_up < 0) e_up = k;
      if (up2 && e_up2 < 0) e_up2 = k;
      if (up && up2) both++;
    end
    checks++; if (e_up !== S + D) begin errors++; $display("FAIL coincide_up edge got %0d want %0d", e_up, S + D); end
    checks++; if (e_up2 !== S + D + 1) begin errors++; $display("FAIL coincide_up2 edge got %0d want %0d", e_up2, S + D + 1); end
    checks++; if (both !== 0) begin errors++; $display("FAIL coincide_overlap got %0d want 0", both); end
  endtask

  task automatic test_clear_drop();
    int e_clr = -1, n_en = 0;
    logic [DROP_W-1:0] drop_before;
    do_reset();
    tick();
    evt_a = 1'b1; evt_b = 1'b1;
    drop_before = '1;
    for (int k = 0; k < 14; k++) begin
      // request seen at the edge that makes the clear cycle line up with both rises
      if (k == S + D - 1) clr_req = 1'b1;
      if (k == 10) clr_req = 1'b0;
      tick();
      if (k == S + D - 1) drop_before = drop;
      if (clr && e_clr < 0) e_clr = k;
      if (up || up2) n_en++;
    end
    checks++; if (drop_before !== '0) begin errors++; $display("FAIL drop_before got %0d want 0", drop_before); end
    checks++; if (e_clr !== S + D) begin errors++; $display("FAIL drop_clear edge got %0d want %0d", e_clr, S + D); end
    checks++; if (n_en !== 0) begin errors++; $display("FAIL drop_enables got %0d want 0", n_en); end
    checks++; if (drop !== 8'd2) begin errors++; $display("FAIL drop_count got %0d want 2", drop); end
  endtask

  task automatic test_clear_hold();
    logic exp_ack;
    int n_clr = 0;
    do_reset();
    clr_req = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k == 10) clr_req = 1'b0;
      tick();
      exp_ack = (k >= 2 && k <= 10);
      if (clr) n_clr++;
      checks++;
      if (clr !== (k == 1)) begin errors++; $display("FAIL hold_clear k=%0d got %b want %b", k, clr, (k == 1)); end
      checks++;
      if (ack !== exp_ack) begin errors++; $display("FAIL hold_ack k=%0d got %b want %b", k, ack, exp_ack); end
    end
    checks++; if (n_clr !== 1) begin errors++; $display("FAIL hold_clear_count got %0d want 1", n_clr); end
  endtask

  task automatic test_reset_mid();
    int first = -1;
    do_reset();
    clr_req = 1'b1; evt_a = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL mid_pre_ack got %b want 1", ack); end
    #2 RSTN = 1'b0;
    #1;
    checks++;
    if ({up, up2, clr, ack} !== 4'b0000 || drop !== '0) begin
      errors++; $display("FAIL mid_reset outputs got %b%b%b%b drop %0d want 0000 drop 0", up, up2, clr, ack, drop);
    end
    do_reset();
    tick();
    evt_a = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (up && first < 0) first = k;
    end
    checks++; if (first !== S + D) begin errors++; $display("FAIL mid_relatency edge got %0d want %0d", first, S + D); end
  endtask

  task automatic test_random();
    int da = 0, db = 0, dr = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (da == 0) begin evt_a = 1'($urandom_range(0, 1)); da = $urandom_range(1, 8); end
      if (db == 0) begin evt_b = 1'($urandom_range(0, 1)); db = $urandom_range(1, 8); end
      if (dr == 0) begin clr_req = 1'($urandom_range(0, 1)); dr = $urandom_range(1, 12); end
      da--; db--; dr--;
      tick();
      checks++; if (up !== m_up) begin errors++; $display("FAIL rand_up cyc=%0d got %b want %b", i, up, m_up); end
      checks++; if (up2 !== m_up2) begin errors++; $display("FAIL rand_up2 cyc=%0d got %b want %b", i, up2, m_up2); end
      checks++; if (clr !== m_clr) begin errors++; $display("FAIL rand_clear cyc=%0d got %b want %b", i, clr, m_clr); end
      checks++; if (ack !== m_ack) begin errors++; $display("FAIL rand_ack cyc=%0d got %b want %b", i, ack, m_ack); end
      checks++;
      if (drop !== DROP_W'(m_drop)) begin errors++; $display("FAIL rand_drop cyc=%0d got %0d want %0d", i, drop, m_drop); end
    end
  endtask

  initial begin
    RSTN = 1'b0; evt_a = 1'b0; evt_b = 1'b0; clr_req = 1'b0;
    model_reset();
    test_reset();
    test_a_latency();
    test_b_glitch();
    test_back_to_back();
    test_clear_drop();
    test_clear_hold();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
